ring_router_mux: RTL and testbench
==================================

RING_ROUTER_MUX -- requirements
Module: ring_router_mux

Interface
REQ-001 Parameters: none; flit type SHALL be dii_package::dii_flit (fields data[15:0], last, valid).
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_ring  input  dii_flit  flits continuing along the ring from the upstream demux.
REQ-005 in_ring_ready  output  1  in_ring flit accepted this cycle when high together with in_ring.valid.
REQ-006 in_local  input  dii_flit  flits injected by the local debug module.
REQ-007 in_local_ready  output  1  in_local flit accepted this cycle when high together with in_local.valid.
REQ-008 out_ring  output  dii_flit  merged flit stream to the downstream ring stage.
REQ-009 out_ring_ready  input  1  downstream accepts out_ring when high together with out_ring.valid.

Function
REQ-010 The block SHALL merge in_ring and in_local onto out_ring at packet (worm) granularity; flits of two packets SHALL never interleave.
REQ-011 Output SHALL be a one-entry register stage (obuf: data, last, valid) driving out_ring directly; out_ring outputs SHALL NOT depend combinationally on any input.
REQ-012 obuf SHALL be able to load when !obuf.valid | out_ring_ready (load_en); full throughput SHALL be 1 flit/cycle.
REQ-013 FSM states: IDLE, RING (worm from in_ring open), LOCAL (worm from in_local open).
REQ-014 In IDLE, the selected source SHALL be: in_ring if only in_ring.valid; in_local if only in_local.valid; if both valid, the source indicated by prio; none if neither valid.
REQ-015 In RING only in_ring SHALL be selected; in LOCAL only in_local SHALL be selected, regardless of the other input's valid.
REQ-016 ready SHALL be asserted only to the selected source, equal to load_en; the unselected input's ready SHALL be 0.
REQ-017 On a transfer (selected valid & ready) obuf SHALL load the selected flit's data and last with valid=1 on the next edge; otherwise, if out_ring_ready, obuf.valid SHALL clear.
REQ-018 Transfer of a non-last flit in IDLE SHALL move to RING/LOCAL per source; transfer of a last flit in RING/LOCAL SHALL return to IDLE; a last flit in IDLE (single-flit packet) SHALL stay in IDLE.
REQ-019 prio (1 bit: 0=ring, 1=local) SHALL update only on transfer of a last flit: set to local after a ring packet completes, to ring after a local packet completes (round-robin).
REQ-020 Latency: a flit accepted at edge N SHALL appear valid on out_ring after edge N (one cycle), held stable while out_ring.valid & !out_ring_ready.
REQ-021 Backpressure: while obuf.valid & !out_ring_ready both input readies SHALL be 0 and state/prio SHALL hold.
REQ-022 A source dropping valid mid-worm SHALL keep the lock; the other source SHALL stay blocked until the locked worm's last flit transfers.
REQ-023 The block SHALL not inspect or modify data (no id decode); data and last SHALL pass unchanged.

Reset
REQ-024 While rst is high (asynchronously): state=IDLE, prio=0 (ring), obuf.valid=0, obuf.data=0, obuf.last=0; both input readies SHALL be 0 while rst is high.
REQ-025 Reset asserted mid-worm SHALL discard the open worm and obuf content; after release the block SHALL arbitrate afresh from IDLE.

Verification
REQ-026 Only in_local valid, 3-flit packet (0x0005,0x1111,0x2222 last), out_ring_ready=1 -> same three flits on out_ring cycles 1-3, last only on 0x2222, in_ring_ready=0 throughout.
REQ-027 Both valid at first edge after reset, 2-flit packets each -> ring packet first (prio=0), then local packet, no interleave; prio=0 again after local last.
REQ-028 Ring worm open, in_ring.valid low 2 cycles, in_local valid -> in_local_ready stays 0 until ring last transfers.
REQ-029 out_ring_ready=0 for 4 cycles with obuf full -> out_ring data/last/valid stable, both readies 0, no flit lost or duplicated after release.
REQ-030 Alternating single-flit packets on both inputs continuously valid -> out_ring alternates ring/local each cycle at 1 flit/cycle.
REQ-031 rst pulse mid 4-flit local worm -> out_ring.valid=0 immediately, state IDLE; next ring single-flit packet passes with 1-cycle latency.

Source files
------------

// File: rtl/ring_router_mux.sv
// Packet-granular 2:1 merge of ring-through and local-injection flit streams
// onto the downstream ring, with round-robin worm arbitration and a registered output stage.
package dii_package;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              valid;
  } dii_flit;
endpackage

module ring_router_mux
  import dii_package::*;
(
  input  logic    clk,
  input  logic    rst,
  input  dii_flit in_ring,
  output logic    in_ring_ready,
  input  dii_flit in_local,
  output logic    in_local_ready,
  output dii_flit out_ring,
  input  logic    out_ring_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RING  = 2'd1,
    LOCAL = 2'd2
  } state_e;

  state_e  state_q, state_d;
  logic    prio_q, prio_d;
  dii_flit obuf_q, obuf_d;

  logic load_en_c;
  logic sel_ring_c;
  logic sel_local_c;
  logic xfer_ring_c;
  logic xfer_local_c;

  assign out_ring = obuf_q;

  // State register; reset discards any open worm and the buffered flit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      obuf_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      obuf_q  <= obuf_d;
    end
  end

  // Next-state: worm lock opens on a non-last transfer, releases on the last one
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (xfer_ring_c && !in_ring.last) begin
          state_d = RING;
        end else if (xfer_local_c && !in_local.last) begin
          state_d = LOCAL;
        end
      end
      RING: begin
        if (xfer_ring_c && in_ring.last) begin
          state_d = IDLE;
        end
      end
      LOCAL: begin
        if (xfer_local_c && in_local.last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer_ring_c && in_ring.last) begin
      prio_d = 1'b1;
    end else if (xfer_local_c && in_local.last) begin
      prio_d = 1'b0;
    end
  end

  // Source select, handshakes and output buffer load
  always_comb begin
    load_en_c   = !obuf_q.valid || out_ring_ready;
    sel_ring_c  = 1'b0;
    sel_local_c = 1'b0;
    obuf_d      = obuf_q;
    case (state_q)
      IDLE: begin
        sel_ring_c  = in_ring.valid && (!in_local.valid || !prio_q);
        sel_local_c = in_local.valid && (!in_ring.valid || prio_q);
      end
      RING:    sel_ring_c  = 1'b1;
      LOCAL:   sel_local_c = 1'b1;
      default: begin
        sel_ring_c  = 1'b0;
        sel_local_c = 1'b0;
      end
    endcase
    in_ring_ready  = sel_ring_c && load_en_c && !rst;
    in_local_ready = sel_local_c && load_en_c && !rst;
    xfer_ring_c    = in_ring.valid && in_ring_ready;
    xfer_local_c   = in_local.valid && in_local_ready;
    if (xfer_ring_c) begin
      obuf_d.data  = in_ring.data;
      obuf_d.last  = in_ring.last;
      obuf_d.valid = 1'b1;
    end else if (xfer_local_c) begin
      obuf_d.data  = in_local.data;
      obuf_d.last  = in_local.last;
      obuf_d.valid = 1'b1;
    end else if (out_ring_ready) begin
      obuf_d.valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_router_mux.sv
// Scoreboard bench for ring_router_mux: per-source flit drivers, an expected-output
// queue filled with hand-ordered flits, and an independent output monitor.
module tb_ring_router_mux;
  import dii_package::*;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  dii_flit in_ring = '0;
  dii_flit in_local = '0;
  logic    in_ring_ready;
  logic    in_local_ready;
  dii_flit out_ring;
  logic    out_ring_ready = 1'b1;

  dii_flit ring_q[$];
  dii_flit loc_q[$];
  exp_t    exp_q[$];

  int checks = 0;
  int errors = 0;

  ring_router_mux dut (
    .clk            (clk),
    .rst            (rst),
    .in_ring        (in_ring),
    .in_ring_ready  (in_ring_ready),
    .in_local       (in_local),
    .in_local_ready (in_local_ready),
    .out_ring       (out_ring),
    .out_ring_ready (out_ring_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_ring(input logic [15:0] d, input logic l, input logic v);
    dii_flit f;
    f.data = d; f.last = l; f.valid = v;
    ring_q.push_back(f);
  endtask

  task automatic push_loc(input logic [15:0] d, input logic l);
    dii_flit f;
    f.data = d; f.last = l; f.valid = 1'b1;
    loc_q.push_back(f);
  endtask

  task automatic push_exp(input logic [15:0] d, input logic l);
    exp_t e;
    e.data = d; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Ring source: a valid=0 entry is a one-cycle bubble
  initial begin
    logic fire;
    forever begin
      @(negedge clk);
      fire = in_ring.valid && in_ring_ready;
      @(posedge clk);
      if (ring_q.size() > 0 && (!ring_q[0].valid || fire)) void'(ring_q.pop_front());
      #1;
      if (ring_q.size() > 0) in_ring = ring_q[0];
      else in_ring = '0;
    end
  end

  initial begin
    logic fire;
    forever begin
      @(negedge clk);
      fire = in_local.valid && in_local_ready;
      @(posedge clk);
      if (loc_q.size() > 0 && fire) void'(loc_q.pop_front());
      #1;
      if (loc_q.size() > 0) in_local = loc_q[0];
      else in_local = '0;
    end
  end

  // Output monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_ring.valid && out_ring_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flit", {15'd0, out_ring.last, out_ring.data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_flit", {15'd0, out_ring.last, out_ring.data}, {15'd0, e.last, e.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    dii_flit snap;

    // Reset, then both sources valid at the first edge after release
    @(posedge clk);
    push_ring(16'hA001, 1'b0, 1'b1); push_ring(16'hA002, 1'b1, 1'b1);
    push_loc(16'hB001, 1'b0);        push_loc(16'hB002, 1'b1);
    push_exp(16'hA001, 1'b0); push_exp(16'hA002, 1'b1);
    push_exp(16'hB001, 1'b0); push_exp(16'hB002, 1'b1);
    @(negedge clk);
    chk("rst_out", 32'(out_ring), 32'd0);
    chk("rst_ring_rdy", 32'(in_ring_ready), 32'd0);
    chk("rst_loc_rdy", 32'(in_local_ready), 32'd0);
    #2 rst = 1'b0;
    wait_drain("drain_both");
    @(posedge clk);
    push_ring(16'h00C0, 1'b1, 1'b1);
    push_loc(16'h00D0, 1'b1);
    push_exp(16'h00C0, 1'b1); push_exp(16'h00D0, 1'b1);
    wait_drain("drain_prio_reset");

    // Local-only 3-flit packet
    @(posedge clk);
    push_loc(16'h0005, 1'b0); push_loc(16'h1111, 1'b0); push_loc(16'h2222, 1'b1);
    push_exp(16'h0005, 1'b0); push_exp(16'h1111, 1'b0); push_exp(16'h2222, 1'b1);
    @(negedge clk);
    chk("loc_lat_valid0", 32'(out_ring.valid), 32'd0);
    chk("loc_rdy", 32'(in_local_ready), 32'd1);
    chk("loc_ring_rdy", 32'(in_ring_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("loc_out_valid", 32'(out_ring.valid), 32'd1);
      chk("loc_ring_rdy", 32'(in_ring_ready), 32'd0);
    end
    wait_drain("drain_local");

    // Ring worm with a 2-cycle valid gap blocks local
    @(posedge clk);
    push_ring(16'h3001, 1'b0, 1'b1);
    push_ring(16'h0000, 1'b0, 1'b0);
    push_ring(16'h0000, 1'b0, 1'b0);
    push_ring(16'h3002, 1'b1, 1'b1);
    push_loc(16'h3101, 1'b1);
    push_exp(16'h3001, 1'b0); push_exp(16'h3002, 1'b1); push_exp(16'h3101, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lock_loc_rdy", 32'(in_local_ready), 32'd0);
    end
    @(negedge clk);
    chk("unlock_loc_rdy", 32'(in_local_ready), 32'd1);
    wait_drain("drain_lock");

    // Output backpressure for 4 cycles with obuf full
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      push_loc(16'h4000 + 16'(i), 1'(i == 3));
      push_exp(16'h4000 + 16'(i), 1'(i == 3));
    end
    @(posedge clk);
    #1 out_ring_ready = 1'b0;
    @(negedge clk);
    snap = out_ring;
    chk("bp_first", {15'd0, out_ring.valid, out_ring.data}, {15'd0, 1'b1, 16'h4000});
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_stable", 32'(out_ring), 32'(snap));
      chk("bp_loc_rdy", 32'(in_local_ready), 32'd0);
      chk("bp_ring_rdy", 32'(in_ring_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ring_ready = 1'b1;
    wait_drain("drain_bp");

    // Alternating single-flit packets at full rate
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      push_ring(16'h5000 + 16'(i), 1'b1, 1'b1);
      push_loc(16'h5100 + 16'(i), 1'b1);
      push_exp(16'h5000 + 16'(i), 1'b1);
      push_exp(16'h5100 + 16'(i), 1'b1);
    end
    @(negedge clk);
    repeat (8) begin
      @(negedge clk);
      chk("thru_valid", 32'(out_ring.valid), 32'd1);
    end
    wait_drain("drain_alt");

    // Reset pulse in the middle of a 4-flit local worm
    @(posedge clk);
    for (int i = 0; i < 4; i++) push_loc(16'h6000 + 16'(i), 1'(i == 3));
    push_exp(16'h6000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    loc_q.delete();
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_ring.valid), 32'd0);
    chk("midrst_out", 32'(out_ring), 32'd0);
    chk("midrst_loc_rdy", 32'(in_local_ready), 32'd0);
    chk("midrst_ring_rdy", 32'(in_ring_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    push_ring(16'h00AA, 1'b1, 1'b1);
    push_exp(16'h00AA, 1'b1);
    @(negedge clk);
    chk("post_rst_valid0", 32'(out_ring.valid), 32'd0);
    chk("post_rst_ring_rdy", 32'(in_ring_ready), 32'd1);
    @(negedge clk);
    chk("post_rst_out", {15'd0, out_ring.valid, out_ring.data}, {15'd0, 1'b1, 16'h00AA});
    wait_drain("drain_post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
